// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- memory-mapped interrupt controller
//
// Sits between six external interrupt sources and the CPU's HWInt[7:2] inputs.
// Each source is latched either on a rising edge or as a level, filtered by a
// mask, and arbitrated by fixed priority (source 5 highest) against the
// in-service set. This allows a higher-priority source to nest inside a
// lower-priority handler. The handler reads CLAIM to take the winning source
// into service and writes EOI to retire it.
//
// Register map (word offset = addr, registers use bits [5:0]):
//   0 MODE  RW   1 = edge, 0 = level
//   1 MASK  RW   1 = enabled
//   2 PEND  R/W1C (W1C only affects edge sources)
//   3 ISR   R    in-service bits
//   4 EOI   W    any write retires the highest in-service source; reads 0
//   5 CLAIM R    winner id 0..5, or 7 when nothing is eligible
//   6,7          read 0, writes ignored
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; clears all state at the next edge
//   irq_src  device requests, bit i = source i
//   sel      bus access to this block this cycle
//   we, re   write / read strobes, qualified by sel (never both high)
//   addr     word offset (PrAddr[4:2])
//   wdata    write data
//   rdata    read data, combinational from the current registers
//   hwint    registered interrupt lines, bit i drives HWInt[2+i]
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter logic [5:0] RESET_MASK = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_src,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  hwint
);

  typedef enum logic [2:0] {
    A_MODE  = 3'd0,
    A_MASK  = 3'd1,
    A_PEND  = 3'd2,
    A_ISR   = 3'd3,
    A_EOI   = 3'd4,
    A_CLAIM = 3'd5
  } reg_addr_e;

  localparam logic [31:0] NO_WINNER = 32'd7;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [5:0] mode;
  logic [5:0] mask;
  logic [5:0] pend;
  logic [5:0] isr;
  logic [5:0] irq_q;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       wr_en;
  logic       rd_en;
  logic       mode_wr;
  logic       mask_wr;
  logic       pend_wr;
  logic       eoi_wr;
  logic       claim_rd;

  assign wr_en    = sel & we;
  assign rd_en    = sel & re;
  assign mode_wr  = wr_en & (reg_addr_e'(addr) == A_MODE);
  assign mask_wr  = wr_en & (reg_addr_e'(addr) == A_MASK);
  assign pend_wr  = wr_en & (reg_addr_e'(addr) == A_PEND);
  assign eoi_wr   = wr_en & (reg_addr_e'(addr) == A_EOI);
  assign claim_rd = rd_en & (reg_addr_e'(addr) == A_CLAIM);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // above_isr[i] is set when no in-service bit sits at index i or higher,
  // i.e. i > top_isr (with top_isr = -1 for an empty ISR).
  logic [5:0] above_isr;
  logic [5:0] eligible;
  logic       win_valid;
  logic [2:0] win_id;
  logic [5:0] eoi_sel;

  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    above_isr = '0;
    for (int i = 0; i < 6; i++) begin
      above_isr[i] = ~|(isr >> i);
    end
  end

  assign eligible = pend & mask & above_isr;

  // Ascending scan: the last set bit seen is the highest-priority one.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_id    = 3'(i);
      end
    end
  end

  // One-hot of the highest in-service bit; EOI retires only that one, so an
  // inner (nested) handler never retires its outer handler's bit.
  always_comb begin
    eoi_sel = '0;
    for (int i = 0; i < 6; i++) begin
      if (isr[i]) begin
        eoi_sel = 6'b000001 << i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state terms
  // ---------------------------------------------------------------------------
  logic       claim;
  logic [5:0] claim_sel;
  logic [5:0] edge_set;
  logic [5:0] edge_clr;
  logic [5:0] mode_chg;
  logic [5:0] pend_next;
  logic [5:0] isr_next;

  // A CLAIM read with nothing eligible returns 7 and must not touch state.
  assign claim     = claim_rd & win_valid;
  assign claim_sel = claim ? (6'b000001 << win_id) : 6'b000000;

  assign edge_set  = irq_src & ~irq_q;
  assign edge_clr  = (pend_wr ? wdata[5:0] : 6'b000000) | claim_sel;

  // Switching a source between edge and level discards whatever it had
  // latched, so a stale level cannot masquerade as a fresh edge.
  assign mode_chg  = mode_wr ? (wdata[5:0] ^ mode) : 6'b000000;

  // Edge sources: set beats clear. Level sources: follow the input directly,
  // which makes W1C and claim ineffective on them.
  assign pend_next = ((mode & (edge_set | (pend & ~edge_clr))) |
                      (~mode & irq_src)) & ~mode_chg;

  // we and re are exclusive, so claim-set and EOI-clear never coincide.
  assign isr_next  = (isr | claim_sel) & ~(eoi_wr ? eoi_sel : 6'b000000);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode  <= '0;
      mask  <= RESET_MASK;
      pend  <= '0;
      isr   <= '0;
      irq_q <= '0;
      hwint <= '0;
    end else begin
      irq_q <= irq_src;
      pend  <= pend_next;
      isr   <= isr_next;
      hwint <= eligible;
      if (mode_wr) begin
        mode <= wdata[5:0];
      end
      if (mask_wr) begin
        mask <= wdata[5:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (reg_addr_e'(addr))
      A_MODE:  rdata = {26'd0, mode};
      A_MASK:  rdata = {26'd0, mask};
      A_PEND:  rdata = {26'd0, pend};
      A_ISR:   rdata = {26'd0, isr};
      A_CLAIM: rdata = win_valid ? {29'd0, win_id} : NO_WINNER;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl
//
// A behavioural model of the controller (plain per-source rules, priority by
// index comparison) predicts every read and the hwint lines each cycle.
// Directed steps walk the handler flows and corner cases, then a randomized
// phase drives random sources, register accesses and occasional resets.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam logic [5:0] TB_RESET_MASK = 6'h21;

  logic        clk;
  logic        reset;
  logic [5:0]  irq_src;
  logic        sel;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hwint;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0]  src_v;
  logic [31:0] last_rdata;

  int_ctrl #(.RESET_MASK(TB_RESET_MASK)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .sel     (sel),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hwint   (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [5:0] m_mode, m_mask, m_pend, m_isr, m_irq_q, m_hwint;

  function automatic int top_isr();
    for (int i = 5; i >= 0; i--) if (m_isr[i]) return i;
    return -1;
  endfunction

  function automatic bit [5:0] m_eligible();
    bit [5:0] e;
    int t;
    e = '0;
    t = top_isr();
    for (int i = 0; i < 6; i++)
      if (m_pend[i] && m_mask[i] && i > t) e[i] = 1'b1;
    return e;
  endfunction

  function automatic int m_winner();
    bit [5:0] e;
    e = m_eligible();
    for (int i = 5; i >= 0; i--) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    int w;
    w = m_winner();
    case (a)
      3'd0:    return {26'd0, m_mode};
      3'd1:    return {26'd0, m_mask};
      3'd2:    return {26'd0, m_pend};
      3'd3:    return {26'd0, m_isr};
      3'd5:    return (w < 0) ? 32'd7 : 32'(w);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit s, input bit w, input bit r,
                            input logic [2:0] a, input logic [31:0] wd,
                            input logic [5:0] src);
    bit [5:0] np, ni, elig;
    int win, top;
    bit wr_pend, is_claim;
    if (rst) begin
      m_mode = '0; m_mask = TB_RESET_MASK; m_pend = '0;
      m_isr = '0; m_irq_q = '0; m_hwint = '0;
      return;
    end
    elig     = m_eligible();
    win      = m_winner();
    top      = top_isr();
    np       = m_pend;
    ni       = m_isr;
    wr_pend  = s && w && a == 3'd2;
    is_claim = s && r && a == 3'd5 && win >= 0;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        if (src[i] && !m_irq_q[i]) np[i] = 1'b1;
        else if ((wr_pend && wd[i]) || (is_claim && win == i)) np[i] = 1'b0;
      end else begin
        np[i] = src[i];
      end
      if (s && w && a == 3'd0 && wd[i] != m_mode[i]) np[i] = 1'b0;
    end
    if (is_claim) ni[win] = 1'b1;
    if (s && w && a == 3'd4 && top >= 0) ni[top] = 1'b0;
    if (s && w && a == 3'd0) m_mode = wd[5:0];
    if (s && w && a == 3'd1) m_mask = wd[5:0];
    m_pend  = np;
    m_isr   = ni;
    m_irq_q = src;
    m_hwint = elig;
  endtask

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check read data before the edge, advance model and
  // DUT through the edge, then check hwint just after it.
  task automatic do_cycle(input bit rst, input bit s, input bit w, input bit r,
                          input logic [2:0] a, input logic [31:0] wd);
    reset = rst; sel = s; we = w; re = r; addr = a; wdata = wd; irq_src = src_v;
    #1;
    last_rdata = rdata;
    if (s && r) check($sformatf("rdata@%0d", a), rdata, m_read(a));
    model_edge(rst, s, w, r, a, wd, src_v);
    @(posedge clk);
    #1;
    check("hwint", {26'd0, hwint}, {26'd0, m_hwint});
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, a, 32'd0);
    check(tag, last_rdata, exp);
  endtask

  task automatic hw(input logic [5:0] exp, input string tag);
    check(tag, {26'd0, hwint}, {26'd0, exp});
  endtask

  // Watchdog: the bench is cycle-counted, so this only fires on a broken run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit       r_rst, r_s, r_w, r_r;
    logic [2:0] r_a;
    int       k;

    src_v = '0;
    reset = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; irq_src = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    hw(6'h00, "reset_hwint");
    rd(3'd0, 32'h00, "reset_mode");
    rd(3'd1, {26'd0, TB_RESET_MASK}, "reset_mask");
    rd(3'd2, 32'h00, "reset_pend");
    rd(3'd3, 32'h00, "reset_isr");

    // Reset/mask: one-cycle pulse on edge source 2
    wr(3'd1, 32'h3F);
    wr(3'd0, 32'h3F);
    src_v = 6'h04;
    idle();
    src_v = 6'h00;
    rd(3'd2, 32'h04, "pend_after_1_edge");
    hw(6'h04, "hwint_after_2_edges");
    rd(3'd5, 32'd2, "claim_src2");
    rd(3'd2, 32'h00, "pend_cleared_by_claim");
    hw(6'h00, "hwint_drop_after_claim");
    rd(3'd3, 32'h04, "isr_after_claim");
    wr(3'd4, 32'h0);
    rd(3'd3, 32'h00, "isr_after_eoi");

    // Priority: sources 1 and 4 rise together
    src_v = 6'h12;
    idle();
    src_v = 6'h00;
    idle();
    hw(6'h12, "prio_hwint_both");
    rd(3'd5, 32'd4, "prio_claim_4");
    idle();
    hw(6'h00, "prio_src1_blocked");
    wr(3'd4, 32'h0);
    idle();
    hw(6'h02, "prio_src1_after_eoi");
    rd(3'd5, 32'd1, "prio_claim_1");

    // Nesting: source 5 arrives while source 1 is in service
    rd(3'd3, 32'h02, "nest_isr_outer");
    src_v = 6'h20;
    idle();
    src_v = 6'h00;
    idle();
    hw(6'h20, "nest_hwint_5");
    rd(3'd5, 32'd5, "nest_claim_5");
    rd(3'd3, 32'h22, "nest_isr_both");
    wr(3'd4, 32'h0);
    rd(3'd3, 32'h02, "nest_isr_after_eoi1");
    wr(3'd4, 32'h0);
    rd(3'd3, 32'h00, "nest_isr_after_eoi2");

    // Level mode on source 0
    wr(3'd0, 32'h00);
    wr(3'd1, 32'h01);
    src_v = 6'h01;
    idle();
    idle();
    hw(6'h01, "level_hwint");
    rd(3'd5, 32'd0, "level_claim_0");
    idle();
    idle();
    hw(6'h00, "level_blocked_in_service");
    wr(3'd4, 32'h0);
    idle();
    hw(6'h01, "level_reassert_after_eoi");
    src_v = 6'h00;
    idle();
    idle();
    hw(6'h00, "level_dropped");

    // Claim with no winner
    rd(3'd5, 32'd7, "claim_no_winner");
    rd(3'd3, 32'h00, "isr_unchanged_no_winner");
    rd(3'd6, 32'h00, "read_off6");

    // W1C racing a new edge on source 3: set wins
    wr(3'd0, 32'h3F);
    wr(3'd1, 32'h3F);
    src_v = 6'h08;
    wr(3'd2, 32'h08);
    src_v = 6'h00;
    rd(3'd2, 32'h08, "w1c_vs_set");
    wr(3'd2, 32'h08);
    rd(3'd2, 32'h00, "w1c_clears");

    // Masked pending source never reaches hwint
    wr(3'd1, 32'h00);
    src_v = 6'h01;
    idle();
    src_v = 6'h00;
    idle();
    idle();
    hw(6'h00, "masked_no_hwint");
    rd(3'd2, 32'h01, "masked_still_pending");
    rd(3'd5, 32'd7, "masked_no_claim");

    // Reset during a claim cycle
    wr(3'd1, 32'h01);
    idle();
    hw(6'h01, "pre_reset_hwint");
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 32'd0);
    rd(3'd3, 32'h00, "reset_during_claim_isr");
    rd(3'd1, {26'd0, TB_RESET_MASK}, "reset_during_claim_mask");
    rd(3'd2, 32'h00, "reset_during_claim_pend");

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) src_v = 6'($urandom);
      r_rst = ($urandom_range(0, 299) == 0);
      k     = int'($urandom_range(0, 9));
      r_s   = (k < 7);
      r_w   = $urandom_range(0, 1) == 1;
      r_r   = !r_w;
      if (k < 2)      r_a = 3'd5;
      else if (k < 3) r_a = 3'd4;
      else            r_a = 3'($urandom_range(0, 7));
      // Keep MODE writes rare so edge sources get a chance to latch.
      if (r_s && r_w && r_a == 3'd0 && $urandom_range(0, 3) != 0) r_a = 3'd1;
      do_cycle(r_rst, r_s, r_w, r_r, r_a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between the external interrupt sources and the CPU's `HWInt[7:2]` inputs. It latches six device requests, either edge- or level-sensitive per source, and applies a mask. It arbitrates by fixed priority with in-service nesting, and exposes claim/EOI registers that the exception handler uses to sequence service. It sits on the system bridge beside the timers and is accessed through the bridge's device bus in the MEM stage.

## Interface

Parameters:
- `RESET_MASK`, default 6'b000000: MASK register value after reset.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high. Clears all state on the next rising edge.
- `irq_src` in 6: device requests; bit i is source i. Source 5 has the highest priority.
- `sel` in 1: the bridge decoded an access to this block this cycle.
- `we` in 1: write strobe, qualified by `sel`.
- `re` in 1: read strobe, qualified by `sel`. Drives the CLAIM side effect. `we` and `re` are never both high.
- `addr` in 3: word offset, `PrAddr[4:2]`.
- `wdata` in 32: write data, `PrWD`.
- `rdata` out 32: read data. Combinational from the current registers.
- `hwint` out 6: registered interrupt lines to CPU `HWInt[7:2]`. Bit i maps to `HWInt[2+i]`.

## Operation

Register map (word offsets). Registers use bits [5:0]; other read bits are 0 and other write bits are ignored.
- 0 MODE, RW. 1 = edge, 0 = level. Reset value 0.
- 1 MASK, RW. 1 = enabled. Reset value `RESET_MASK`.
- 2 PEND, R/W1C. Write-1-clear affects edge sources only.
- 3 ISR, R. In-service bits.
- 4 EOI, W. Any write clears the highest-numbered set ISR bit. No effect if ISR is 0. Reads return 0.
- 5 CLAIM, R. Returns the id (0..5) of the winner, or 32'd7 if there is no winner.
- 6, 7: reads return 0; writes are ignored.

Pending logic:
- `irq_q` is `irq_src` registered each cycle.
- Edge source: PEND[i] sets when `irq_src[i] & ~irq_q[i]`. It stays set until W1C or claim.
- Level source: PEND[i] is loaded with `irq_src[i]` every cycle. W1C and claim do not clear it.
- If a set condition and a clear condition hit the same bit in the same cycle, the set wins.
- A MODE write that changes bit i clears PEND[i] that cycle. This overrides a set.

Arbitration:
- `top_isr` is the index of the highest set ISR bit, or -1 if ISR is 0.
- `eligible[i] = PEND[i] & MASK[i] & (i > top_isr)`.
- The winner is the highest set bit of `eligible`.
- `hwint` is `eligible` registered. Masked, lower-priority and equal-priority sources never reach the CPU.

Claim sequence (a read of CLAIM with `sel & re`):
- `rdata` returns the winner id.
- At the same edge: ISR[winner] sets, and PEND[winner] clears if that source is edge-mode.
- With no winner: returns 7 and nothing changes.
- The handler flow is: claim, service, write EOI, then `eret`.

Nesting:
- A higher-priority source that becomes eligible while a lower one is in service raises its `hwint` bit.
- The EOI from the inner handler retires only the inner ISR bit.

## Timing

- Reset values: `hwint` = 0, `irq_q` = 0, PEND = 0, ISR = 0, MODE = 0, MASK = `RESET_MASK`. `rdata` then follows the reset registers.
- Interrupt latency:
  - `irq_src[i]` goes high before edge k, so PEND[i] is set after edge k.
  - `hwint[i]` goes high after edge k+1.
  - Total: 2 edges.
- Register writes (MASK, MODE, W1C, EOI) take effect at the edge ending the access cycle. `hwint` reflects them one edge later.
- A claim updates ISR/PEND at the edge ending the read cycle. `hwint[winner]` drops one edge after that.
- A held level source stays in PEND but is blocked from `hwint` by `i > top_isr` until its EOI.
- Reset asserted mid-service (ISR ≠ 0, or a claim in the same cycle): the reset wins, and all state returns to reset values after that edge.
- An access with `sel` = 0 has no effect, regardless of `we`/`re`.

## Test plan

- Reset/mask:
  - Stimulus: reset, MASK = 0x3F, MODE = 0x3F, pulse `irq_src[2]` for one cycle.
  - Required: PEND = 0x04 after 1 edge, `hwint` = 0x04 after 2 edges.
  - Then CLAIM reads 2, PEND = 0, ISR = 0x04, `hwint` = 0. EOI write leaves ISR = 0.
- Priority:
  - Stimulus: edge sources 1 and 4 rise in the same cycle.
  - Required: `hwint` = 0x12. CLAIM returns 4, then `hwint` = 0x00 because source 1 is blocked.
  - Then EOI, `hwint` = 0x02, and the next CLAIM returns 1.
- Nesting:
  - Stimulus: claim source 1 (ISR = 0x02), then raise edge source 5.
  - Required: `hwint` = 0x20. CLAIM returns 5, ISR = 0x22.
  - First EOI leaves ISR = 0x02, second EOI leaves ISR = 0x00.
- Level mode:
  - Stimulus: MODE = 0, MASK = 0x01, hold `irq_src[0]` high.
  - Required: CLAIM returns 0 and `hwint` = 0 while in service.
  - EOI with the input still high gives `hwint` = 0x01 again after one edge. Drop the input and `hwint` = 0 two edges later.
- Boundaries:
  - CLAIM with no winner returns 7 and changes nothing.
  - W1C on PEND[3] in the same cycle as a new edge on source 3 leaves PEND[3] = 1.
  - A masked pending source never drives `hwint`.
  - Reset asserted during a claim cycle leaves ISR = 0.
